// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - fetch PC register with static next-PC prediction and a return-address stack
module next_pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              RAS_DEPTH  = 4,
    parameter bit              BR_PRED_EN = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         stall,
    input  logic                         inst_valid,
    input  logic [31:0]                  instruction,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              next_pc,
    output logic                         pred_taken,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_ovf
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CW-1:0]   FULL    = CW'(RAS_DEPTH);

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   sp;     // next free slot; top of stack sits at sp-1

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            is_jal, is_jalr, is_branch;
    logic            rd_link, rs1_link, is_ret;
    logic            push, pop, swap, ras_upd;
    logic [XLEN-1:0] j_imm, b_imm, seq_pc, ras_top;
    logic [PW-1:0]   top_idx;
    logic            ras_wen;
    logic [PW-1:0]   ras_waddr;

    assign opcode    = instruction[6:0];
    assign rd        = instruction[11:7];
    assign rs1       = instruction[19:15];
    assign is_jal    = inst_valid && (opcode == OP_JAL);
    assign is_jalr   = inst_valid && (opcode == OP_JALR);
    assign is_branch = inst_valid && (opcode == OP_BRANCH);
    assign rd_link   = (rd == 5'd1) || (rd == 5'd5);
    assign rs1_link  = (rs1 == 5'd1) || (rs1 == 5'd5);
    assign is_ret    = is_jalr && rs1_link && (rd == 5'd0) && (instruction[31:20] == 12'd0);

    assign j_imm = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
    assign b_imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};

    assign seq_pc  = pc + PC_STEP;
    assign top_idx = sp - PW'(1);
    assign ras_top = ras[top_idx];

    // Coroutine swap (link rd and a different link rs1) pops and pushes at once.
    assign push    = (is_jal || is_jalr) && rd_link;
    assign pop     = is_ret || (is_jalr && rd_link && rs1_link && (rd != rs1));
    assign swap    = push && pop && (ras_count != '0);
    assign ras_upd = rst_n && !stall && !redirect_valid && inst_valid;

    always_comb begin
        next_pc    = seq_pc;
        pred_taken = 1'b0;
        if (redirect_valid) begin
            next_pc = redirect_pc;
        end else if (is_ret && (ras_count != '0)) begin
            next_pc    = ras_top;
            pred_taken = 1'b1;
        end else if (is_jal) begin
            next_pc    = pc + j_imm;
            pred_taken = 1'b1;
        end else if (is_branch && instruction[31] && BR_PRED_EN) begin
            next_pc    = pc + b_imm;
            pred_taken = 1'b1;
        end
    end

    always_comb begin
        ras_wen   = 1'b0;
        ras_waddr = sp;
        if (ras_upd && swap) begin
            ras_wen   = 1'b1;
            ras_waddr = top_idx;
        end else if (ras_upd && push) begin
            ras_wen = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_wen) begin
            ras[ras_waddr] <= seq_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            sp        <= '0;
            ras_count <= '0;
            ras_ovf   <= 1'b0;
        end else if (!stall) begin
            pc <= next_pc;
            if (ras_upd && !swap) begin
                if (push) begin
                    // A full stack wraps onto its oldest entry.
                    sp <= sp + PW'(1);
                    if (ras_count == FULL) begin
                        ras_ovf <= 1'b1;
                    end else begin
                        ras_count <= ras_count + CW'(1);
                    end
                end else if (pop && (ras_count != '0)) begin
                    sp        <= top_idx;
                    ras_count <= ras_count - CW'(1);
                end
            end
        end
    end
endmodule

// File: doc/next_pc_gen.md
Name: next_pc_gen

Overview:
Parametrised next-PC generator for the IF stage. It owns the architectural fetch PC register and predicts the next fetch address from the instruction fetched at the current PC:
- JAL is always taken.
- Conditional branches use static backward-taken prediction.
- Returns use a circular return-address stack (RAS).
- Execute-stage redirects override every prediction.

Parameters:
XLEN, 32, PC and address width; the immediate is sign-extended to XLEN.
RESET_PC, 32'h0000_0000, PC value loaded on reset.
RAS_DEPTH, 4, number of RAS entries; power of two, at least 2.
BR_PRED_EN, 1, 1 = backward conditional branches predicted taken; 0 = never predicted taken.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  synchronous reset, active-low.
stall  input  1  hold the PC and all state this cycle.
inst_valid  input  1  instruction holds the word fetched at pc.
instruction  input  32  instruction fetched at the current pc.
redirect_valid  input  1  execute-stage mispredict or JALR resolution.
redirect_pc  input  XLEN  corrected fetch address.
pc  output  XLEN  current fetch PC (registered).
next_pc  output  XLEN  combinational address loaded at the next unstalled edge.
pred_taken  output  1  combinational; the current instruction is predicted to leave the sequential path.
ras_count  output  $clog2(RAS_DEPTH)+1  valid RAS entries.
ras_ovf  output  1  sticky flag: a push overwrote a live entry.

Behaviour:
- Reset: rst_n=0 sampled at a clock edge sets pc=RESET_PC, ras_count=0, ras_ovf=0 and the RAS pointer to 0. Reset overrides stall and redirect. Reset mid-stream discards all RAS contents.
- Decode is valid only when inst_valid=1. When inst_valid=0, pred_taken=0, next_pc=pc+4 and the RAS is untouched.
- Opcodes: JAL 1101111, JALR 1100111, BRANCH 1100011.
- Immediates:
  - J-type: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - B-type: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - Both sign-extended to XLEN. Targets are computed as pc+imm modulo 2^XLEN (wrap, no fault).
- Link register: rd in {x1,x5}. Return: JALR with rs1 in {x1,x5}, rd=x0, imm=0.
- next_pc priority, highest first:
  1. redirect_valid → redirect_pc.
  2. Return with ras_count>0 → RAS top.
  3. JAL → pc+J-imm.
  4. BRANCH with inst[31]=1 and BR_PRED_EN=1 → pc+B-imm.
  5. Otherwise → pc+4. This includes a return with an empty RAS and any non-return JALR.
- pred_taken=1 exactly when case 2, 3 or 4 applies and redirect_valid=0.
- Latency: next_pc is combinational from the current pc/instruction; pc takes that value one cycle later. There are no bubbles.
- stall=1 with no reset: pc, the RAS, ras_count and ras_ovf all hold. Outputs still reflect the held pc.
- RAS update happens only on an unstalled edge with redirect_valid=0 and inst_valid=1:
  - Push pc+4 when the instruction is JAL or JALR with a link rd.
  - Pop when it is a return.
  - Push+pop in the same cycle (JALR with link rd and link rs1 where rd≠rs1, i.e. a coroutine swap): the top entry is replaced with pc+4; the count is unchanged.
  - JALR with rd=rs1, both link registers: push only.
- Full RAS push: the write lands at the wrapped pointer, overwriting the oldest entry. ras_count saturates at RAS_DEPTH and ras_ovf is set; it is cleared only by reset.
- Empty RAS pop: no pointer or count change; the prediction falls back to pc+4.
- redirect_valid=1: the current instruction is squashed. No RAS push or pop occurs; the RAS is not repaired. Redirect during stall is ignored, so the source must hold redirect_valid until it sees the stall drop.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with stall=1 → pc=0x0, ras_count=0, ras_ovf=0. Release with NOPs (0x00000013) → pc = 0x4, 0x8, 0xC on successive cycles.
- JAL call then return: at pc=0x100 feed 0x020000EF (jal x1,+0x20) → pred_taken=1, next pc=0x120, ras_count=1. At 0x120 feed 0x00008067 (ret) → next pc=0x104, ras_count=0.
- Backward branch: at pc=0x208 feed 0xFE000CE3 (beq x0,x0,-8) → pc=0x200, pred_taken=1. Repeat with BR_PRED_EN=0 → pc=0x20C, pred_taken=0.
- RAS wrap and underflow (RAS_DEPTH=4):
  - Five chained JAL x1 calls from 0x0,0x100,0x200,0x300,0x400 → ras_count=4, ras_ovf=1.
  - Five rets → targets 0x404,0x304,0x204,0x104, then pc+4 on the fifth.
- Redirect priority: at pc=0x100 with JAL 0x020000EF and redirect_valid=1, redirect_pc=0x800 → pc=0x800, pred_taken=0, ras_count unchanged.
- Stall and wrap-around:
  - stall=1 for 3 cycles with JAL present → pc and ras_count frozen.
  - pc=0xFFFFFFFC with a NOP → pc=0x0.
